// File: rtl/mono_video_out_pkg.sv
// Shared types, default palette and colour helpers
// for the monochrome video output stage.
package mono_video_pkg;

  typedef logic [23:0] rgb24_t;

  localparam rgb24_t DEFAULT_PAL [4] = '{
    24'hFFFFFF,
    24'h33FF33,
    24'hFFCC00,
    24'h40FFA6
  };

  // Entries beyond the built-in table reset to white.
  function automatic rgb24_t default_pal(
    input int unsigned idx
  );
    logic [1:0] i2;
    i2 = idx[1:0];
    if (idx < 4) return DEFAULT_PAL[i2];
    return 24'hFFFFFF;
  endfunction

  function automatic rgb24_t dim_half(
    input rgb24_t c
  );
    return {c[23:16] >> 1,
            c[15:8] >> 1,
            c[7:0] >> 1};
  endfunction

  // (ch * (luma + 1)) >> 8 in a 16-bit product:
  // luma=FF passes ch through, luma=0 gives 0.
  function automatic logic [7:0] scale_ch(
    input logic [7:0] c,
    input logic [7:0] l
  );
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, l} + 16'd1);
    return 8'(p >> 8);
  endfunction

  function automatic rgb24_t luma_scale(
    input rgb24_t fg,
    input logic [7:0] luma
  );
    return {scale_ch(fg[23:16], luma),
            scale_ch(fg[15:8], luma),
            scale_ch(fg[7:0], luma)};
  endfunction

endpackage

// File: rtl/mono_video_out_ce_divider.sv
// Pixel clock-enable divider: one-cycle ce every
// 2**DIV_LOG2 clk_sys cycles (ce tied high for 0).
module ce_divider #(
  parameter int DIV_LOG2 = 3
) (
  input  logic clk_sys,
  input  logic reset_in,
  output logic ce
);

  if (DIV_LOG2 == 0) begin : g_tied
    assign ce = 1'b1;
  end else begin : g_cnt
    logic [DIV_LOG2-1:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_in)
      if (!reset_in) cnt <= '0;
      else           cnt <= cnt + DIV_LOG2'(1);

    assign ce = &cnt;
  end

endmodule

// File: rtl/mono_video_out.sv
// Monochrome video output: ce_pix generation, palette
// lookup, luma/scanline shading, sync alignment.
// Ports: clk_sys/reset_in, ce_pix, pix/hs/vs/blank in,
// pal_sel/scanlines, palette write port, rgb/hs/vs/de out.
import mono_video_pkg::*;

module mono_video_out #(
  parameter int DIV_LOG2  = 3,
  parameter int PIX_W     = 8,
  parameter int NUM_PAL   = 4,
  parameter int LUMA_MODE = 0,
  localparam int PAL_SEL_W =
    (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic                 clk_sys,
  input  logic                 reset_in,
  output logic                 ce_pix,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic                 blank_in,
  input  logic [PAL_SEL_W-1:0] pal_sel,
  input  logic                 scanlines,
  input  logic                 pal_wr_en,
  input  logic [PAL_SEL_W-1:0] pal_wr_addr,
  input  logic [23:0]          pal_wr_data,
  output logic [7:0]           r_out,
  output logic [7:0]           g_out,
  output logic [7:0]           b_out,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 de_out
);

  localparam logic [PAL_SEL_W:0] NP =
    (PAL_SEL_W+1)'(NUM_PAL);

  ce_divider #(
    .DIV_LOG2(DIV_LOG2)
  ) u_ce (
    .clk_sys (clk_sys),
    .reset_in(reset_in),
    .ce      (ce_pix)
  );

  rgb24_t pal [NUM_PAL];

  always_ff @(posedge clk_sys or negedge reset_in)
    if (!reset_in) begin
      for (int i = 0; i < NUM_PAL; i++)
        pal[i] <= default_pal(i);
    end else if (pal_wr_en &&
                 {1'b0, pal_wr_addr} < NP) begin
      pal[pal_wr_addr] <= pal_wr_data;
    end

  logic [PIX_W-1:0]     s1_pix;
  logic                 s1_hs;
  logic                 s1_vs;
  logic                 s1_blank;
  rgb24_t               s1_fg;
  logic [PAL_SEL_W-1:0] active_pal;
  logic                 active_scan;
  logic                 parity;

  // S1 holds the previous sample, so it doubles
  // as the edge detector for the incoming syncs.
  logic vs_rise;
  logic hs_rise;
  assign vs_rise = vs_in & ~s1_vs;
  assign hs_rise = hs_in & ~s1_hs;

  logic [7:0] luma;
  if (PIX_W >= 8) begin : g_trunc
    assign luma = s1_pix[PIX_W-1 -: 8];
  end else begin : g_pad
    assign luma = {s1_pix, {(8-PIX_W){1'b0}}};
  end

  rgb24_t col;
  always_comb begin
    col = (LUMA_MODE != 0) ?
      luma_scale(s1_fg, luma) :
      ((|s1_pix) ? s1_fg : '0);
    if (active_scan && parity)
      col = dim_half(col);
    if (s1_blank)
      col = '0;
  end

  always_ff @(posedge clk_sys or negedge reset_in)
    if (!reset_in) begin
      s1_pix      <= '0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_blank    <= 1'b0;
      s1_fg       <= '0;
      active_pal  <= '0;
      active_scan <= 1'b0;
      parity      <= 1'b0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      de_out      <= 1'b0;
    end else if (ce_pix) begin
      s1_pix   <= pix_in;
      s1_hs    <= hs_in;
      s1_vs    <= vs_in;
      s1_blank <= blank_in;
      s1_fg    <= pal[active_pal];
      if (vs_rise) begin
        if ({1'b0, pal_sel} < NP)
          active_pal <= pal_sel;
        active_scan <= scanlines;
        parity      <= 1'b0;
      end else if (hs_rise) begin
        parity <= ~parity;
      end
      r_out  <= col[23:16];
      g_out  <= col[15:8];
      b_out  <= col[7:0];
      hs_out <= s1_hs;
      vs_out <= s1_vs;
      de_out <= ~s1_blank;
    end

endmodule

// File: tb/tb_mono_video_out.sv
// Self-checking bench for mono_video_out: binary
// and luma builds compared against a behavioural model.
module tb_mono_video_out;

  logic        clk_sys = 1'b0;
  logic        reset_in = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic        blank_in = 1'b0;
  logic [1:0]  pal_sel = '0;
  logic        scanlines = 1'b0;
  logic        pal_wr_en = 1'b0;
  logic [1:0]  pal_wr_addr = '0;
  logic [23:0] pal_wr_data = '0;

  logic       ce_a, hs_a, vs_a, de_a;
  logic [7:0] r_a, g_a, b_a;
  logic       ce_b, hs_b, vs_b, de_b;
  logic [7:0] r_b, g_b, b_b;
  logic [26:0] out_a, out_b;
  assign out_a = {r_a, g_a, b_a, hs_a, vs_a, de_a};
  assign out_b = {r_b, g_b, b_b, hs_b, vs_b, de_b};

  int checks = 0;
  int errors = 0;
  bit hs_r, vs_r;

  always #5 clk_sys = ~clk_sys;

  mono_video_out #(
    .DIV_LOG2(3), .PIX_W(8),
    .NUM_PAL(4), .LUMA_MODE(0)
  ) u_dut (
    .clk_sys(clk_sys), .reset_in(reset_in),
    .ce_pix(ce_a), .pix_in(pix_in),
    .hs_in(hs_in), .vs_in(vs_in),
    .blank_in(blank_in), .pal_sel(pal_sel),
    .scanlines(scanlines), .pal_wr_en(pal_wr_en),
    .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data),
    .r_out(r_a), .g_out(g_a), .b_out(b_a),
    .hs_out(hs_a), .vs_out(vs_a), .de_out(de_a)
  );

  mono_video_out #(
    .DIV_LOG2(3), .PIX_W(8),
    .NUM_PAL(3), .LUMA_MODE(1)
  ) u_lm (
    .clk_sys(clk_sys), .reset_in(reset_in),
    .ce_pix(ce_b), .pix_in(pix_in),
    .hs_in(hs_in), .vs_in(vs_in),
    .blank_in(blank_in), .pal_sel(pal_sel),
    .scanlines(scanlines), .pal_wr_en(pal_wr_en),
    .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data),
    .r_out(r_b), .g_out(g_b), .b_out(b_b),
    .hs_out(hs_b), .vs_out(vs_b), .de_out(de_b)
  );

  // ---- behavioural model (per ce tick) ----
  logic [23:0] m_pal [2][4];
  int          m_np [2] = '{4, 3};
  int          m_lm [2] = '{0, 1};
  int          m_act [2];
  bit          m_scan [2];
  bit          m_par [2];
  bit          m_pvs, m_phs;
  logic [7:0]  q_pix;
  bit          q_hs, q_vs, q_blank;
  logic [23:0] q_fg [2];
  bit          q_scan [2];
  bit          q_par [2];
  logic [26:0] m_exp [2];

  function automatic logic [26:0] render(int i);
    logic [23:0] c;
    int ch;
    c = '0;
    if (m_lm[i] != 0) begin
      for (int k = 0; k < 3; k++) begin
        ch = int'(q_fg[i][8*k +: 8]);
        c[8*k +: 8] = 8'(ch * (int'(q_pix) + 1) / 256);
      end
    end else if (q_pix != 0) begin
      c = q_fg[i];
    end
    if (q_scan[i] && q_par[i])
      for (int k = 0; k < 3; k++)
        c[8*k +: 8] = c[8*k +: 8] / 2;
    if (q_blank) c = '0;
    return {c, q_hs, q_vs, !q_blank};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pal[i][0] = 24'hFFFFFF;
      m_pal[i][1] = 24'h33FF33;
      m_pal[i][2] = 24'hFFCC00;
      m_pal[i][3] = 24'h40FFA6;
      m_act[i] = 0; m_scan[i] = 0; m_par[i] = 0;
      q_fg[i] = '0; q_scan[i] = 0; q_par[i] = 0;
    end
    m_pvs = 0; m_phs = 0;
    q_pix = '0; q_hs = 0; q_vs = 0; q_blank = 0;
  endtask

  task automatic model_write(
    input logic [1:0] a, input logic [23:0] d);
    for (int i = 0; i < 2; i++)
      if (int'(a) < m_np[i]) m_pal[i][a] = d;
  endtask

  task automatic model_tick(
    input logic [7:0] pix, input bit hs, vs, blank,
    input logic [1:0] sel, input bit sc,
    input bit wen, input logic [1:0] wa,
    input logic [23:0] wd);
    logic [23:0] nfg [2];
    bit vr, hr;
    for (int i = 0; i < 2; i++) begin
      m_exp[i] = render(i);
      nfg[i] = m_pal[i][m_act[i]];
    end
    if (wen) model_write(wa, wd);
    vr = vs && !m_pvs;
    hr = hs && !m_phs;
    for (int i = 0; i < 2; i++) begin
      if (vr) begin
        if (int'(sel) < m_np[i]) m_act[i] = int'(sel);
        m_scan[i] = sc;
        m_par[i] = 0;
      end else if (hr) begin
        m_par[i] = !m_par[i];
      end
    end
    m_pvs = vs; m_phs = hs;
    q_pix = pix; q_hs = hs; q_vs = vs; q_blank = blank;
    for (int i = 0; i < 2; i++) begin
      q_fg[i] = nfg[i];
      q_scan[i] = m_scan[i];
      q_par[i] = m_par[i];
    end
  endtask

  // ---- helpers ----
  task automatic check(input string name,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_in = 0; pix_in = 0; hs_in = 0; vs_in = 0;
    blank_in = 0; pal_sel = 0; scanlines = 0;
    pal_wr_en = 0; hs_r = 0; vs_r = 0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_in = 1;
    model_reset();
  endtask

  // Apply one sample at the next ce tick; an optional
  // palette write is asserted on that same clock only.
  task automatic ce_step(
    input logic [7:0] pix, input bit hs, vs, blank,
    input logic [1:0] sel, input bit sc,
    input bit wen, input logic [1:0] wa,
    input logic [23:0] wd);
    bit found;
    found = 0;
    pix_in = pix; hs_in = hs; vs_in = vs;
    blank_in = blank; pal_sel = sel; scanlines = sc;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk_sys);
      if (ce_a) begin
        found = 1;
        pal_wr_en = wen;
        pal_wr_addr = wa;
        pal_wr_data = wd;
      end
    end
    check("ce_seen", {31'd0, found}, 32'd1);
    @(posedge clk_sys);
    #1;
    pal_wr_en = 0;
    model_tick(pix, hs, vs, blank, sel, sc, wen, wa, wd);
    check("bin_out", {5'd0, out_a}, {5'd0, m_exp[0]});
    check("luma_out", {5'd0, out_b}, {5'd0, m_exp[1]});
  endtask

  task automatic step(
    input logic [7:0] pix, input bit hs, vs, blank,
    input logic [1:0] sel, input bit sc);
    ce_step(pix, hs, vs, blank, sel, sc, 0, 2'd0, 24'd0);
  endtask

  task automatic pal_write(
    input logic [1:0] a, input logic [23:0] d);
    @(negedge clk_sys);
    pal_wr_en = 1; pal_wr_addr = a; pal_wr_data = d;
    @(posedge clk_sys);
    #1;
    pal_wr_en = 0;
    model_write(a, d);
  endtask

  typedef struct {
    logic [7:0]  pix;
    bit          hs, vs, blank;
    logic [1:0]  sel;
    bit          sc;
    logic [23:0] rgb;
    bit          ehs, evs, ede;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{8'h01,0,0,0,2'd1,0,24'h000000,0,0,1};
    tbl[1]  = '{8'h01,0,1,0,2'd1,0,24'hFFFFFF,0,0,1};
    tbl[2]  = '{8'h01,0,0,0,2'd1,0,24'hFFFFFF,0,1,1};
    tbl[3]  = '{8'h00,0,0,0,2'd2,0,24'h33FF33,0,0,1};
    tbl[4]  = '{8'h01,0,0,0,2'd2,0,24'h000000,0,0,1};
    tbl[5]  = '{8'h01,0,0,1,2'd2,0,24'h33FF33,0,0,1};
    tbl[6]  = '{8'h01,0,0,0,2'd2,0,24'h000000,0,0,0};
    tbl[7]  = '{8'h01,0,1,0,2'd2,0,24'h33FF33,0,0,1};
    tbl[8]  = '{8'h01,0,0,0,2'd2,1,24'h33FF33,0,1,1};
    tbl[9]  = '{8'h01,0,0,0,2'd2,1,24'hFFCC00,0,0,1};
    tbl[10] = '{8'h01,1,0,0,2'd2,1,24'hFFCC00,0,0,1};
    tbl[11] = '{8'h01,0,0,0,2'd2,1,24'hFFCC00,1,0,1};

    // reset state
    do_reset();
    #1;
    check("rst_out_a", {5'd0, out_a}, 32'd0);
    check("rst_out_b", {5'd0, out_b}, 32'd0);
    check("rst_ce", {31'd0, ce_a}, 32'd0);

    // ce cadence: high for the clock ending at edge 8k
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("ce_cadence", {31'd0, ce_a},
            {31'd0, (k % 8) == 7});
    end

    // table: palette select, pix 0, blank, mid-frame
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].pix, tbl[i].hs, tbl[i].vs,
           tbl[i].blank, tbl[i].sel, tbl[i].sc);
      check("tbl_vec", {5'd0, out_a},
            {5'd0, tbl[i].rgb, tbl[i].ehs,
             tbl[i].evs, tbl[i].ede});
    end

    // scanlines, coincident hs/vs rise
    do_reset();
    step(8'h01, 0, 1, 0, 2'd0, 1);
    step(8'h01, 0, 0, 0, 2'd0, 1);
    check("scan_even", {8'd0, out_a[26:3]}, 32'hFFFFFF);
    step(8'h01, 1, 0, 0, 2'd0, 1);
    step(8'h01, 0, 0, 0, 2'd0, 1);
    check("scan_odd", {8'd0, out_a[26:3]}, 32'h7F7F7F);
    step(8'h01, 1, 1, 0, 2'd0, 1);
    step(8'h01, 0, 0, 0, 2'd0, 1);
    check("scan_vs_wins", {8'd0, out_a[26:3]},
          32'hFFFFFF);

    // luma scaling, out-of-range pal_sel
    do_reset();
    step(8'h80, 0, 1, 0, 2'd2, 0);
    step(8'h80, 0, 0, 0, 2'd2, 0);
    step(8'hFF, 0, 0, 0, 2'd2, 0);
    check("luma_80", {8'd0, out_b[26:3]}, 32'h806600);
    step(8'h00, 0, 0, 0, 2'd2, 0);
    check("luma_ff", {8'd0, out_b[26:3]}, 32'hFFCC00);
    step(8'hFF, 0, 1, 0, 2'd3, 0);
    step(8'hFF, 0, 0, 0, 2'd3, 0);
    step(8'hFF, 0, 0, 0, 2'd3, 0);
    check("sel_oob", {8'd0, out_b[26:3]}, 32'hFFCC00);
    check("sel_3", {8'd0, out_a[26:3]}, 32'h40FFA6);

    // palette writes and mid-line reset
    do_reset();
    step(8'h01, 0, 1, 0, 2'd0, 0);
    step(8'h01, 0, 0, 0, 2'd0, 0);
    pal_write(2'd0, 24'h123456);
    step(8'h01, 0, 0, 0, 2'd0, 0);
    step(8'h01, 0, 0, 0, 2'd0, 0);
    check("wr_live", {8'd0, out_a[26:3]}, 32'h123456);
    ce_step(8'h01, 0, 0, 0, 2'd0, 0,
            1, 2'd0, 24'hABCDEF);
    step(8'h01, 0, 0, 0, 2'd0, 0);
    check("wr_same_old", {8'd0, out_a[26:3]},
          32'h123456);
    step(8'h01, 0, 0, 0, 2'd0, 0);
    check("wr_same_new", {8'd0, out_a[26:3]},
          32'hABCDEF);
    pal_write(2'd3, 24'h000001);
    step(8'h01, 1, 0, 0, 2'd0, 0);
    @(posedge clk_sys);
    #3;
    reset_in = 0;
    #1;
    check("mid_rst_a", {5'd0, out_a}, 32'd0);
    check("mid_rst_b", {5'd0, out_b}, 32'd0);
    check("mid_rst_ce", {31'd0, ce_a}, 32'd0);
    do_reset();
    step(8'h01, 0, 1, 0, 2'd0, 0);
    step(8'h01, 0, 0, 0, 2'd0, 0);
    step(8'h01, 0, 0, 0, 2'd0, 0);
    check("pal_default", {8'd0, out_a[26:3]},
          32'hFFFFFF);

    // randomized traffic against the model
    for (int n = 0; n < 160; n++) begin
      logic [7:0] p;
      int r;
      r = $urandom_range(0, 3);
      p = (r == 0) ? 8'h00 :
          (r == 1) ? 8'hFF :
          (r == 2) ? 8'h80 : 8'($urandom);
      if ($urandom_range(0, 4) == 0) hs_r = !hs_r;
      if ($urandom_range(0, 14) == 0) vs_r = !vs_r;
      if ($urandom_range(0, 9) == 0)
        pal_write(2'($urandom), 24'($urandom));
      ce_step(p, hs_r, vs_r,
              $urandom_range(0, 4) == 0,
              2'($urandom), 1'($urandom),
              $urandom_range(0, 7) == 0,
              2'($urandom), 24'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
